// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU sequencer: FSM state encoding and sizing limits.
package mcu_pkg;

    localparam int DEFAULT_ADDR_W = 10;
    localparam int CONV_LAT_MAX   = 15;
    localparam int DRAIN_CNT_W    = $clog2(CONV_LAT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CONV  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seqState_t;

endpackage

// File: rtl/mcu_sequencer_if.sv
// Host/memory control bundle of the MCU sequencer.
// The i_abort signal exists only when MCU_SEQ_ABORT_EN is defined.
interface mcu_sequencer_if
    import mcu_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
);
    logic              i_start;
    logic [ADDR_W-1:0] i_length;
    logic              i_dataValid;
`ifdef MCU_SEQ_ABORT_EN
    logic              i_abort;
`endif
    logic              o_ready;
    logic              o_inputCtrl;
    logic              o_memCtrl;
    logic              o_convCtrl;
    logic              o_wrEn;
    logic [ADDR_W-1:0] o_wrAddr;
    logic [ADDR_W-1:0] o_rdAddr;
    logic              o_done;

`ifdef MCU_SEQ_ABORT_EN
    modport master (
        output i_start, i_length, i_dataValid, i_abort,
        input  o_ready, o_inputCtrl, o_memCtrl, o_convCtrl,
               o_wrEn, o_wrAddr, o_rdAddr, o_done
    );
    modport slave (
        input  i_start, i_length, i_dataValid, i_abort,
        output o_ready, o_inputCtrl, o_memCtrl, o_convCtrl,
               o_wrEn, o_wrAddr, o_rdAddr, o_done
    );
`else
    modport master (
        output i_start, i_length, i_dataValid,
        input  o_ready, o_inputCtrl, o_memCtrl, o_convCtrl,
               o_wrEn, o_wrAddr, o_rdAddr, o_done
    );
    modport slave (
        input  i_start, i_length, i_dataValid,
        output o_ready, o_inputCtrl, o_memCtrl, o_convCtrl,
               o_wrEn, o_wrAddr, o_rdAddr, o_done
    );
`endif

endinterface

// File: rtl/mcu_delay_line.sv
// Flushable shift register delaying a {valid, address} word by DEPTH cycles.
module mcu_delay_line #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] dIn,
    output logic [WIDTH-1:0] dOut
);
    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
            stages[0] <= dIn;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    assign dOut = stages[DEPTH-1];

endmodule

// File: rtl/mcu_sequencer.sv
// MCU sequencer: loads a column strip from the host, convolves it from the other bank, drains results.
// Defining MCU_SEQ_ABORT_EN adds the i_abort input and its return-to-IDLE path.
module mcu_sequencer
    import mcu_pkg::*;
#(
    parameter int N           = 2,
    parameter int BITS_IMAGEN = 8,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int CONV_LAT    = 3
) (
    input logic            i_clk,
    input logic            i_rst,
    mcu_sequencer_if.slave bus
);
    if (CONV_LAT < 1 || CONV_LAT > CONV_LAT_MAX || N < 1 || BITS_IMAGEN < 1) begin : gBadParams
        $error("mcu_sequencer: parameter out of range");
    end

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(CONV_LAT - 1);

    seqState_t              state, stateNext;
    logic [ADDR_W-1:0]      len, lenLast, wcnt, rcnt;
    logic [DRAIN_CNT_W-1:0] dcnt;
    logic                   bank, phase;
    logic                   latchLen, toggleBanks, abortReq, inConv;
    logic [ADDR_W:0]        wbWord;
    logic                   dlValid;
    logic [ADDR_W-1:0]      dlAddr;

`ifdef MCU_SEQ_ABORT_EN
    assign abortReq = bus.i_abort && (state != IDLE);
`else
    assign abortReq = 1'b0;
`endif

    assign lenLast = len - ADDR_W'(1);
    assign inConv  = (state == CONV) || (state == DRAIN);

    always_comb begin
        stateNext   = state;
        latchLen    = 1'b0;
        toggleBanks = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    latchLen  = 1'b1;
                    stateNext = (bus.i_length == '0) ? DONE : LOAD;
                end
            end
            LOAD:    if (bus.i_dataValid && wcnt == lenLast) stateNext = CONV;
            CONV:    if (rcnt == lenLast) stateNext = DRAIN;
            DRAIN:   if (dcnt == DRAIN_LAST) stateNext = DONE;
            DONE: begin
                stateNext   = IDLE;
                toggleBanks = 1'b1;
            end
            default: stateNext = IDLE;
        endcase
        // Abort wins over everything and leaves bank/phase untouched.
        if (abortReq) begin
            stateNext   = IDLE;
            toggleBanks = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            len   <= '0;
            wcnt  <= '0;
            rcnt  <= '0;
            dcnt  <= '0;
            bank  <= 1'b0;
            phase <= 1'b0;
        end else begin
            state <= stateNext;
            if (latchLen) len <= bus.i_length;
            if (stateNext != state) begin
                wcnt <= '0;
                rcnt <= '0;
                dcnt <= '0;
            end else begin
                if (state == LOAD && bus.i_dataValid) wcnt <= wcnt + 1'b1;
                if (state == CONV) rcnt <= rcnt + 1'b1;
                if (state == DRAIN) dcnt <= dcnt + 1'b1;
            end
            if (toggleBanks) begin
                bank  <= ~bank;
                phase <= ~phase;
            end
        end
    end

    // Each issued read re-emerges CONV_LAT cycles later as a write-back request.
    mcu_delay_line #(
        .DEPTH(CONV_LAT),
        .WIDTH(ADDR_W + 1)
    ) uWriteBack (
        .clk  (i_clk),
        .rst  (i_rst),
        .flush(abortReq),
        .dIn  ({state == CONV, rcnt}),
        .dOut (wbWord)
    );

    assign dlValid = wbWord[ADDR_W];
    assign dlAddr  = wbWord[ADDR_W-1:0];

    assign bus.o_ready     = (state == IDLE);
    assign bus.o_inputCtrl = inConv;
    assign bus.o_memCtrl   = (state == LOAD) ? bank : (inConv ? ~bank : 1'b0);
    assign bus.o_convCtrl  = (state == CONV) && phase;
    assign bus.o_wrEn      = (state == LOAD) ? bus.i_dataValid : (inConv && dlValid);
    assign bus.o_wrAddr    = (state == LOAD) ? wcnt : (inConv ? dlAddr : '0);
    assign bus.o_rdAddr    = (state == CONV) ? rcnt : '0;
    assign bus.o_done      = (state == DONE) && !abortReq;

endmodule
